apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_req_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
//   Two-requester round-robin front end for an APB master. A winning request
//   is latched into holding registers and then issued to the APB master.
//   The arbiter waits for the bus handshake and returns read data and error
//   status to the winner with a one-cycle done pulse. Every output is
//   registered.
//
//   FSM: IDLE -> XFER (transfer/gnt pulse) -> WAIT (bus in flight) -> RESP
//   (done pulse) -> IDLE. With PREADY on the first WAIT cycle, a minimum
//   transaction is 4 cycles.
//
// Parameters
//   WIDTH    data width; addresses are WIDTH+1 bits, and bit WIDTH selects
//            the slave
//   TIMEOUT  WAIT-state watchdog limit in cycles (only with ARB_TIMEOUT_EN)
//
// Configuration macro
//   ARB_TIMEOUT_EN  when defined, a watchdog ends WAIT after TIMEOUT cycles
//                   with err=1. When undefined, WAIT lasts until PREADY or
//                   PSLVERR.
//
// Ports
//   PCLK, PRESETn            clock; synchronous active-high reset
//   req/rw/addr/wdata 0,1    requester command inputs (req held until done)
//   gnt0/gnt1, done0/done1   one-cycle grant and completion pulses
//   rdata, err               completion data and status, valid with done
//   transfer, read_write,    command to the APB master; stable from XFER
//   write_paddr, read_paddr, until WAIT ends
//   write_data
//   PENABLE, PREADY, PSLVERR bus handshake observed from the APB master
//   read_data_out            read data from the APB master
module apb_req_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             req0,
  input  logic             req1,
  input  logic             rw0,
  input  logic             rw1,
  input  logic [WIDTH:0]   addr0,
  input  logic [WIDTH:0]   addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] rdata,
  output logic             err,
  output logic             transfer,
  output logic             read_write,
  output logic [WIDTH:0]   write_paddr,
  output logic [WIDTH:0]   read_paddr,
  output logic [WIDTH-1:0] write_data,
  input  logic             PENABLE,
  input  logic             PREADY,
  input  logic             PSLVERR,
  input  logic [WIDTH-1:0] read_data_out
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("apb_req_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, XFER, WAIT, RESP} state_t;

  state_t           state, state_nx;
  logic             last_gnt, last_nx;   // 1: requester 1 was served last
  logic             sel, sel_nx;         // requester owning the transaction
  logic             h_rw, h_rw_nx;
  logic [WIDTH:0]   h_addr, h_addr_nx;
  logic [WIDTH-1:0] h_wdata, h_wdata_nx;

  logic             gnt0_nx, gnt1_nx, done0_nx, done1_nx, transfer_nx;
  logic [WIDTH-1:0] rdata_nx;
  logic             err_nx;
  logic             read_write_nx;
  logic [WIDTH:0]   write_paddr_nx, read_paddr_nx;
  logic [WIDTH-1:0] write_data_nx;

  logic             win, win_rw, finish;
  logic [WIDTH:0]   win_addr;
  logic [WIDTH-1:0] win_wdata;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt, cnt_nx;
`endif

  always_comb begin
    state_nx       = state;
    last_nx        = last_gnt;
    sel_nx         = sel;
    h_rw_nx        = h_rw;
    h_addr_nx      = h_addr;
    h_wdata_nx     = h_wdata;
    gnt0_nx        = 1'b0;
    gnt1_nx        = 1'b0;
    done0_nx       = 1'b0;
    done1_nx       = 1'b0;
    transfer_nx    = 1'b0;
    rdata_nx       = rdata;
    err_nx         = err;
    read_write_nx  = read_write;
    write_paddr_nx = write_paddr;
    read_paddr_nx  = read_paddr;
    write_data_nx  = write_data;
    win            = 1'b0;
    win_rw         = 1'b0;
    win_addr       = '0;
    win_wdata      = '0;
    finish         = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_nx         = cnt;
`endif

    case (state)
      IDLE: begin
        if (req0 | req1) begin
          // On contention, the requester not served last wins.
          win       = (req0 & req1) ? ~last_gnt : req1;
          win_rw    = win ? rw1 : rw0;
          win_addr  = win ? addr1 : addr0;
          win_wdata = win ? wdata1 : wdata0;
          sel_nx     = win;
          h_rw_nx    = win_rw;
          h_addr_nx  = win_addr;
          h_wdata_nx = win_wdata;
          // Load the bus outputs now so they are valid during XFER.
          gnt0_nx        = ~win;
          gnt1_nx        = win;
          transfer_nx    = 1'b1;
          read_write_nx  = win_rw;
          write_paddr_nx = win_rw ? win_addr : '0;
          read_paddr_nx  = win_rw ? '0 : win_addr;
          write_data_nx  = win_wdata;
          state_nx       = XFER;
        end
      end

      XFER: begin
        read_write_nx  = h_rw;
        write_paddr_nx = h_rw ? h_addr : '0;
        read_paddr_nx  = h_rw ? '0 : h_addr;
        write_data_nx  = h_wdata;
`ifdef ARB_TIMEOUT_EN
        cnt_nx         = '0;
`endif
        state_nx       = WAIT;
      end

      WAIT: begin
        if (PENABLE & PREADY) begin
          rdata_nx = h_rw ? '0 : read_data_out;
          err_nx   = PSLVERR;
          finish   = 1'b1;
        end else if (PSLVERR) begin
          rdata_nx = '0;
          err_nx   = 1'b1;
          finish   = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          rdata_nx = '0;
          err_nx   = 1'b1;
          finish   = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
`endif
        if (finish) begin
          done0_nx       = ~sel;
          done1_nx       = sel;
          read_write_nx  = 1'b0;
          write_paddr_nx = '0;
          read_paddr_nx  = '0;
          write_data_nx  = '0;
          state_nx       = RESP;
        end
      end

      RESP: begin
        last_nx  = sel;
        state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      state       <= IDLE;
      last_gnt    <= 1'b1;  // requester 0 wins the first contention
      sel         <= 1'b0;
      h_rw        <= 1'b0;
      h_addr      <= '0;
      h_wdata     <= '0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      transfer    <= 1'b0;
      rdata       <= '0;
      err         <= 1'b0;
      read_write  <= 1'b0;
      write_paddr <= '0;
      read_paddr  <= '0;
      write_data  <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt         <= '0;
`endif
    end else begin
      state       <= state_nx;
      last_gnt    <= last_nx;
      sel         <= sel_nx;
      h_rw        <= h_rw_nx;
      h_addr      <= h_addr_nx;
      h_wdata     <= h_wdata_nx;
      gnt0        <= gnt0_nx;
      gnt1        <= gnt1_nx;
      done0       <= done0_nx;
      done1       <= done1_nx;
      transfer    <= transfer_nx;
      rdata       <= rdata_nx;
      err         <= err_nx;
      read_write  <= read_write_nx;
      write_paddr <= write_paddr_nx;
      read_paddr  <= read_paddr_nx;
      write_data  <= write_data_nx;
`ifdef ARB_TIMEOUT_EN
      cnt         <= cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter
//   Testbench for apb_req_arbiter. A transaction-level model of the two
//   requesters tracks pending requests and the last requester served. From
//   these it predicts the winner, the bus command, and the completion
//   result for each transaction. Stimulus is driven and outputs are sampled
//   on the falling clock edge.
module tb_apb_req_arbiter;
  localparam int W = 32;

  logic         PCLK = 1'b0;
  logic         PRESETn;
  logic         req0, req1, rw0, rw1;
  logic [W:0]   addr0, addr1;
  logic [W-1:0] wdata0, wdata1;
  logic         gnt0, gnt1, done0, done1;
  logic [W-1:0] rdata;
  logic         err, transfer, read_write;
  logic [W:0]   write_paddr, read_paddr;
  logic [W-1:0] write_data;
  logic         PENABLE, PREADY, PSLVERR;
  logic [W-1:0] read_data_out;

  apb_req_arbiter #(.WIDTH(W), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .err(err), .transfer(transfer), .read_write(read_write),
    .write_paddr(write_paddr), .read_paddr(read_paddr), .write_data(write_data),
    .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .read_data_out(read_data_out)
  );

  always #5 PCLK = ~PCLK;

  int vectors = 0;
  int miscompares = 0;

  // Requester model: pending flag and command per requester, and the last
  // requester served (-1 after reset, meaning none).
  int         last_w;
  bit         pend [2];
  bit         prw [2];
  logic [W:0] paddr [2];
  logic [W-1:0] pwdata [2];
  int         gw;
  bit         quiet;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] rnd_addr();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[W:0];
  endfunction

  task automatic new_req(input int i);
    pend[i]   = 1'b1;
    prw[i]    = 1'($urandom_range(0, 1));
    paddr[i]  = rnd_addr();
    pwdata[i] = $urandom;
  endtask

  task automatic drive_reqs();
    req0 = pend[0]; rw0 = prw[0]; addr0 = paddr[0]; wdata0 = pwdata[0];
    req1 = pend[1]; rw1 = prw[1]; addr1 = paddr[1]; wdata1 = pwdata[1];
  endtask

  task automatic do_reset();
    PRESETn = 1'b1;
    req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    PENABLE = 0; PREADY = 0; PSLVERR = 0; read_data_out = '0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b0;
    last_w  = -1;
    pend[0] = 0; pend[1] = 0;
  endtask

  // Runs one transaction. The task starts and ends at a falling edge with the
  // DUT in IDLE. d is the number of extra WAIT cycles before completion.
  // slv ends the transaction with PSLVERR instead of PREADY. drop releases
  // the winner's req and scrambles its inputs after the grant.
  task automatic run_round(input int d, input bit slv, input logic [W-1:0] rv,
                           input bit drop, output int got_w);
    int           w;
    logic [W:0]   ewa, era;
    logic [W-1:0] erd;
    logic [1:0]   eg;
    if (pend[0] && pend[1]) w = (last_w == 0) ? 1 : 0;
    else                    w = pend[1] ? 1 : 0;
    eg  = (w == 0) ? 2'b10 : 2'b01;
    ewa = prw[w] ? paddr[w] : '0;
    era = prw[w] ? '0 : paddr[w];
    erd = (slv || prw[w]) ? '0 : rv;
    drive_reqs();
    PENABLE = 0; PREADY = 0; PSLVERR = 0;

    @(negedge PCLK);
    got_w = gnt1 ? 1 : 0;
    check("xfer_transfer", transfer, 1);
    check("xfer_gnt", {gnt0, gnt1}, eg);
    check("xfer_rw", read_write, prw[w]);
    check("xfer_wpaddr", write_paddr, ewa);
    check("xfer_rpaddr", read_paddr, era);
    check("xfer_wdata", write_data, pwdata[w]);
    check("xfer_done", {done0, done1}, 0);
    if (drop) begin
      if (w == 0) begin req0 = 0; rw0 = ~rw0; addr0 = rnd_addr(); wdata0 = $urandom; end
      else        begin req1 = 0; rw1 = ~rw1; addr1 = rnd_addr(); wdata1 = $urandom; end
    end

    for (int j = 1; j <= d + 1; j++) begin
      @(negedge PCLK);
      check("wait_ctl", {transfer, gnt0, gnt1, done0, done1}, 0);
      check("wait_rw_wpaddr", {read_write, write_paddr}, {prw[w], ewa});
      check("wait_rpaddr", read_paddr, era);
      check("wait_wdata", write_data, pwdata[w]);
      PENABLE       = 1;
      PREADY        = (j == d + 1) && !slv;
      PSLVERR       = (j == d + 1) && slv;
      read_data_out = (j == d + 1) ? rv : $urandom;
    end

    @(negedge PCLK);
    check("resp_done", {done0, done1}, eg);
    check("resp_rdata", rdata, erd);
    check("resp_err", err, slv);
    check("resp_quiet", {transfer, gnt0, gnt1}, 0);
    PENABLE = 0; PREADY = 0; PSLVERR = 0;
    last_w  = w;
    pend[w] = 0;

    @(negedge PCLK);
    check("idle_quiet", {transfer, gnt0, gnt1, done0, done1}, 0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_ctl", {gnt0, gnt1, done0, done1, transfer, read_write, err}, 0);
    check("rst_wpaddr", write_paddr, 0);
    check("rst_rpaddr", read_paddr, 0);
    check("rst_data", {write_data, rdata}, 0);

    // Single write from requester 0, PREADY on the first PENABLE cycle
    pend[0] = 1; prw[0] = 1; paddr[0] = 33'h1_0000_0010; pwdata[0] = 32'hDEAD_BEEF;
    run_round(0, 0, $urandom, 0, gw);
    check("w40_winner", gw, 0);

    // Read from requester 1 with PREADY delayed 3 cycles; req dropped mid-way
    pend[1] = 1; prw[1] = 0; paddr[1] = 33'h0_0000_0004; pwdata[1] = $urandom;
    run_round(3, 0, 32'h1234_5678, 1, gw);
    check("r41_winner", gw, 1);

    // Both requesters held high from reset: grants alternate 0,1,0,1
    do_reset();
    prw[0] = 1; paddr[0] = rnd_addr(); pwdata[0] = $urandom;
    prw[1] = 0; paddr[1] = rnd_addr(); pwdata[1] = $urandom;
    for (int i = 0; i < 4; i++) begin
      pend[0] = 1; pend[1] = 1;
      run_round(i % 2, 0, $urandom, 0, gw);
      check("alt_order", gw, i % 2);
    end
    pend[0] = 0; pend[1] = 0;

    // Slave error, then a normal transaction
    pend[0] = 1; prw[0] = 0; paddr[0] = rnd_addr(); pwdata[0] = $urandom;
    run_round(1, 1, $urandom, 0, gw);
    pend[1] = 1; prw[1] = 1; paddr[1] = rnd_addr(); pwdata[1] = $urandom;
    run_round(0, 0, $urandom, 0, gw);
    check("after_err_winner", gw, 1);

    // Reset during WAIT: outputs clear, no done, req0 then wins contention
    pend[1] = 1; prw[1] = 1; paddr[1] = rnd_addr(); pwdata[1] = $urandom;
    drive_reqs();
    @(negedge PCLK);
    check("rstw_xfer", {transfer, gnt1}, 2'b11);
    @(negedge PCLK);
    PENABLE = 1; PREADY = 0;
    PRESETn = 1;
    @(negedge PCLK);
    check("rstw_ctl", {gnt0, gnt1, done0, done1, transfer, read_write, err}, 0);
    check("rstw_paddr", {write_paddr, read_paddr}, 0);
    check("rstw_data", {write_data, rdata}, 0);
    PRESETn = 0; PENABLE = 0;
    last_w = -1;
    new_req(0); new_req(1);
    run_round(0, 0, $urandom, 0, gw);
    check("rstw_first", gw, 0);
    run_round(0, 0, $urandom, 0, gw);
    check("rstw_second", gw, 1);

    // WAIT with PREADY held low
    pend[0] = 1; prw[0] = 0; paddr[0] = rnd_addr(); pwdata[0] = $urandom;
    drive_reqs();
    @(negedge PCLK);
    check("hang_xfer", {transfer, gnt0}, 2'b11);
    PENABLE = 1; PREADY = 0; PSLVERR = 0;
    quiet = 1;
`ifdef ARB_TIMEOUT_EN
    for (int j = 1; j <= 16; j++) begin
      @(negedge PCLK);
      if (done0 || done1) quiet = 0;
    end
    check("to_no_early_done", quiet, 1);
    @(negedge PCLK);
    check("to_done", {done0, done1}, 2'b10);
    check("to_err", err, 1);
    check("to_rdata", rdata, 0);
`else
    for (int j = 1; j <= 100; j++) begin
      @(negedge PCLK);
      if (done0 || done1) quiet = 0;
    end
    check("hang_no_done", quiet, 1);
    PREADY = 1; read_data_out = 32'hA5A5_0F0F;
    @(negedge PCLK);
    check("hang_done", {done0, done1}, 2'b10);
    check("hang_rdata", rdata, 32'hA5A5_0F0F);
    check("hang_err", err, 0);
`endif
    PENABLE = 0; PREADY = 0;
    last_w = 0; pend[0] = 0;
    @(negedge PCLK);
    check("hang_idle", {transfer, done0, done1}, 0);

    // Randomized traffic
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && ($urandom_range(0, 1) == 1)) new_req(i);
      if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
      run_round(int'($urandom_range(0, 4)), ($urandom_range(0, 5) == 0), $urandom,
                ($urandom_range(0, 2) == 0), gw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
